// File: rtl/reset_pkg.sv
// Shared types and legal parameter ranges for the reset sequencer.
package reset_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // A zero hold length still asserts every channel for one cycle.
  function automatic int hold_eff(input int hold_cycles);
    return (hold_cycles == 0) ? 1 : hold_cycles;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Channel-side signal bundle of the reset sequencer.
interface reset_sequencer_if #(
  parameter int NUM_CH = 4
);
  import reset_pkg::*;

  // Handshake: sync_reset[i] low means channel i is released; the sequencer
  // moves past channel i only after ch_ready[i] is sampled high, with no
  // timeout. done rises once the last channel is released and acknowledged.
  logic              soft_reset;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] sync_reset;
  logic              done;
  state_e            dbg_state;

  modport master (
    output soft_reset,
    output ch_ready,
    input  sync_reset,
    input  done,
    input  dbg_state
  );

  modport slave (
    input  soft_reset,
    input  ch_ready,
    output sync_reset,
    output done,
    output dbg_state
  );

endinterface

// File: rtl/reset_sync.sv
// Reset deassertion synchroniser: async clear, data input tied high.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic sync_n_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Holds all channel resets, then releases them one by one, bit 0 first,
// spacing releases by a stagger interval and waiting for each acknowledge.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 1000,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              I_CLK,
  input  logic              I_ASYNC_RESET_N,
  input  logic              I_SOFT_RESET,
  input  logic [NUM_CH-1:0] I_CH_READY,
  output logic [NUM_CH-1:0] O_SYNC_RESET,
  output logic              O_DONE,
  output state_e            O_DBG_STATE
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("reset_sequencer: SYNC_STAGES out of range");
  end
  if (HOLD_CYCLES < 0 || (CNT_W < 32 && (HOLD_CYCLES >> CNT_W) != 0)) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES does not fit in CNT_W bits");
  end
  if (STAGGER_CYCLES < 0 || (CNT_W < 32 && (STAGGER_CYCLES >> CNT_W) != 0)) begin : g_bad_stagger
    $error("reset_sequencer: STAGGER_CYCLES does not fit in CNT_W bits");
  end

  localparam int HOLD_EFF = hold_eff(HOLD_CYCLES);
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // The cycle in which the synchroniser output first reads high is already
  // the first hold cycle, so leaving SYNC loads one less than a soft reload.
  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_FIRST   = CNT_W'((HOLD_EFF > 1) ? HOLD_EFF - 2 : 0);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  state_e            state_q;
  logic [NUM_CH-1:0] rst_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;

  logic              sync_n;
  logic              ready_cur;
  logic [NUM_CH-1:0] adv_mask;
  logic              cnt_zero;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk_i    (I_CLK),
    .rst_n_i  (I_ASYNC_RESET_N),
    .sync_n_o (sync_n)
  );

  // Acknowledge of the most recently released channel, and the next bit to clear.
  always_comb begin
    ready_cur = 1'b0;
    adv_mask  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ready_cur = I_CH_READY[i];
      end
      if (i > 0 && idx_q == IDX_W'(i - 1)) begin
        adv_mask[i] = 1'b1;
      end
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_N) begin
    if (!I_ASYNC_RESET_N) begin
      state_q <= SYNC;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (I_SOFT_RESET && state_q != SYNC) begin
      state_q <= HOLD;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cnt_q   <= HOLD_RELOAD;
      idx_q   <= '0;
    end else begin
      case (state_q)
        SYNC: begin
          if (sync_n) begin
            if (HOLD_EFF == 1) begin
              rst_q[0] <= 1'b0;
              idx_q    <= '0;
              cnt_q    <= STAGGER_LOAD;
              state_q  <= RELEASE;
            end else begin
              cnt_q   <= HOLD_FIRST;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            rst_q[0] <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= STAGGER_LOAD;
            state_q  <= RELEASE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (idx_q == LAST_IDX) begin
            if (ready_cur) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (cnt_zero && ready_cur) begin
            rst_q <= rst_q & ~adv_mask;
            idx_q <= idx_q + IDX_W'(1);
            cnt_q <= STAGGER_LOAD;
          end else if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= SYNC;
        end
      endcase
    end
  end

  assign O_SYNC_RESET = rst_q;
  assign O_DONE       = done_q;
  assign O_DBG_STATE  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: three-channel sequencer (hold 10, stagger 4) and a
// single-channel sequencer with zero hold, checked against edge timelines.
module tb_reset_sequencer;
  import reset_pkg::*;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  logic [3:0] exp_q[$];
  logic [1:0] exp_b_q[$];

  reset_sequencer_if #(.NUM_CH(3)) bus_a ();
  reset_sequencer_if #(.NUM_CH(1)) bus_b ();

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH         (3),
    .HOLD_CYCLES    (10),
    .STAGGER_CYCLES (4),
    .CNT_W          (16),
    .SYNC_STAGES    (2)
  ) u_dut_a (
    .I_CLK           (clk),
    .I_ASYNC_RESET_N (rst_n_a),
    .I_SOFT_RESET    (bus_a.soft_reset),
    .I_CH_READY      (bus_a.ch_ready),
    .O_SYNC_RESET    (bus_a.sync_reset),
    .O_DONE          (bus_a.done),
    .O_DBG_STATE     (bus_a.dbg_state)
  );

  reset_sequencer #(
    .NUM_CH         (1),
    .HOLD_CYCLES    (0),
    .STAGGER_CYCLES (4),
    .CNT_W          (16),
    .SYNC_STAGES    (2)
  ) u_dut_b (
    .I_CLK           (clk),
    .I_ASYNC_RESET_N (rst_n_b),
    .I_SOFT_RESET    (bus_b.soft_reset),
    .I_CH_READY      (bus_b.ch_ready),
    .O_SYNC_RESET    (bus_b.sync_reset),
    .O_DONE          (bus_b.done),
    .O_DBG_STATE     (bus_b.dbg_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called one time unit after a clock edge: pulses reset low between edges,
  // checks outputs with no clock edge, and releases so the next edge is edge 1.
  task automatic pulse_reset(input bit sel_b);
    #2;
    if (sel_b) rst_n_b = 1'b0;
    else       rst_n_a = 1'b0;
    #1;
    if (sel_b) begin
      check("b_async_out", {6'b0, bus_b.done, bus_b.sync_reset}, 8'b0000_0001);
      check("b_async_state", {6'b0, bus_b.dbg_state}, {6'b0, SYNC});
    end else begin
      check("a_async_out", {4'b0, bus_a.done, bus_a.sync_reset}, 8'b0000_0111);
      check("a_async_state", {6'b0, bus_a.dbg_state}, {6'b0, SYNC});
    end
    #2;
    if (sel_b) rst_n_b = 1'b1;
    else       rst_n_a = 1'b1;
  endtask

  // Edges first..last of DUT A. r0..r2 are release edges, d the done edge;
  // rdy0_edge raises ch_ready[0] in time to be sampled at that edge; soft
  // reset is sampled high on soft_len edges starting at soft_edge.
  task automatic run_a(input int first, input int last, input int r0, input int r1,
                       input int r2, input int d, input int rdy0_edge,
                       input int soft_edge, input int soft_len);
    logic [3:0] exp_v;
    for (int e = first; e <= last; e++) begin
      if (rdy0_edge != 0 && e == rdy0_edge) bus_a.ch_ready[0] = 1'b1;
      bus_a.soft_reset = (soft_len > 0 && e >= soft_edge && e < soft_edge + soft_len);
      exp_q.push_back({(e >= d), (e < r2), (e < r1), (e < r0)});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check($sformatf("a_edge%0d", e), {4'b0, bus_a.done, bus_a.sync_reset}, {4'b0, exp_v});
    end
    bus_a.soft_reset = 1'b0;
  endtask

  task automatic run_b(input int first, input int last, input int r0, input int d,
                       input int rdy_edge);
    logic [1:0] exp_v;
    for (int e = first; e <= last; e++) begin
      if (rdy_edge != 0 && e == rdy_edge) bus_b.ch_ready = 1'b1;
      exp_b_q.push_back({(e >= d), (e < r0)});
      @(posedge clk);
      #1;
      exp_v = exp_b_q.pop_front();
      check($sformatf("b_edge%0d", e), {6'b0, bus_b.done, bus_b.sync_reset}, {6'b0, exp_v});
    end
  endtask

  initial begin
    rst_n_a          = 1'b0;
    rst_n_b          = 1'b0;
    bus_a.soft_reset = 1'b0;
    bus_a.ch_ready   = 3'b111;
    bus_b.soft_reset = 1'b0;
    bus_b.ch_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("a_reset_out", {4'b0, bus_a.done, bus_a.sync_reset}, 8'b0000_0111);
    check("a_reset_state", {6'b0, bus_a.dbg_state}, {6'b0, SYNC});
    check("b_reset_out", {6'b0, bus_b.done, bus_b.sync_reset}, 8'b0000_0001);

    // Basic sequence with all acknowledges high.
    pulse_reset(1'b0);
    run_a(1, 5, 12, 16, 20, 21, 0, 0, 0);
    check("a_state_hold", {6'b0, bus_a.dbg_state}, {6'b0, HOLD});
    run_a(6, 13, 12, 16, 20, 21, 0, 0, 0);
    check("a_state_release", {6'b0, bus_a.dbg_state}, {6'b0, RELEASE});
    run_a(14, 24, 12, 16, 20, 21, 0, 0, 0);
    check("a_state_done", {6'b0, bus_a.dbg_state}, {6'b0, DONE});
    bus_a.ch_ready = 3'b000;
    run_a(25, 27, 12, 16, 20, 21, 0, 0, 0);
    bus_a.ch_ready = 3'b111;

    // Channel 0 acknowledge withheld until edge 30.
    bus_a.ch_ready = 3'b110;
    pulse_reset(1'b0);
    run_a(1, 37, 12, 30, 34, 35, 30, 0, 0);
    bus_a.ch_ready = 3'b111;

    // One-cycle soft reset at edge 17, then soft reset held over edges 40..44.
    pulse_reset(1'b0);
    run_a(1, 16, 12, 16, 20, 21, 0, 0, 0);
    run_a(17, 39, 27, 31, 35, 36, 0, 17, 1);
    run_a(40, 64, 54, 58, 62, 63, 0, 40, 5);
    check("a_state_done2", {6'b0, bus_a.dbg_state}, {6'b0, DONE});

    // Async reset mid-release, then a full replay; soft reset in SYNC is ignored.
    pulse_reset(1'b0);
    run_a(1, 17, 12, 16, 20, 21, 0, 0, 0);
    pulse_reset(1'b0);
    run_a(1, 24, 12, 16, 20, 21, 0, 1, 1);

    // Single channel, zero hold: acknowledge late, then acknowledge already high.
    bus_b.ch_ready = 1'b0;
    pulse_reset(1'b1);
    run_b(1, 10, 3, 8, 8);
    check("b_state_done", {6'b0, bus_b.dbg_state}, {6'b0, DONE});
    pulse_reset(1'b1);
    bus_b.ch_ready = 1'b1;
    run_b(1, 6, 3, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
